// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch requester: owns the PC, fetches from INST_MEM and buffers
// up to two {pc, instr} pairs for decode over a valid/ready handshake.
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] PC,
  input  logic [31:0] Instruction_Code,
  input  logic        fetch_en,
  output logic        fetch_valid,
  output logic [31:0] fetch_instr,
  output logic [31:0] fetch_pc,
  input  logic        fetch_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        addr_misaligned
);

  // Handshake: a transfer to decode completes on any rising edge where
  // fetch_valid and fetch_ready are both 1; the head then advances.
  localparam logic [1:0] FULL = QDEPTH[1:0];

  logic [1:0]  count;
  logic [31:0] tail_pc;
  logic [31:0] tail_instr;
  logic        pop;
  logic        push;
  logic        wr_head;
  logic        wr_tail;
  logic        shift;

  assign fetch_valid = (count != 2'd0);
  assign pop         = fetch_valid & fetch_ready;
  assign push        = fetch_en & ~redirect_valid & ((count != FULL) | pop);

  // The head slot drives the decode outputs directly; the tail slot only
  // exists when two entries are held.
  assign wr_head = push & ((count == 2'd0) | ((count == 2'd1) & pop));
  assign wr_tail = push & ~wr_head;
  assign shift   = pop & (count == 2'd2);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count           <= 2'd0;
      PC              <= RESET_PC;
      fetch_pc        <= 32'd0;
      fetch_instr     <= 32'd0;
      tail_pc         <= 32'd0;
      tail_instr      <= 32'd0;
      addr_misaligned <= 1'b0;
    end else begin
      addr_misaligned <= redirect_valid & (redirect_pc[1:0] != 2'b00);
      if (redirect_valid) begin
        count <= 2'd0;
        PC    <= {redirect_pc[31:2], 2'b00};
      end else begin
        count <= count + {1'b0, push} - {1'b0, pop};
        if (push) begin
          PC <= PC + 32'd4;
        end
        if (shift) begin
          fetch_pc    <= tail_pc;
          fetch_instr <= tail_instr;
        end
        if (wr_head) begin
          fetch_pc    <= PC;
          fetch_instr <= Instruction_Code;
        end
        if (wr_tail) begin
          tail_pc    <= PC;
          tail_instr <= Instruction_Code;
        end
      end
    end
  end

endmodule

// File: doc/inst_fetch_ctrl.md
Name: inst_fetch_ctrl

Overview:
- Requester side of the instruction-memory interface: owns the program counter, drives `PC` into INST_MEM and captures the returned `Instruction_Code`.
- Buffers fetched instructions in a 2-entry queue and presents them to decode over a valid/ready handshake.
- Accepts redirects (branch/jump) from execute, which flush the queue and restart fetch at the target.
- Sits between INST_MEM and the decode stage in the Instruction Fetch Unit.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- QDEPTH, 2, fetch queue entries (fixed at 2; not required to be generic).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-low; sampled on rising clk edge.
- PC  output  32  fetch address to INST_MEM.
- Instruction_Code  input  32  instruction word from INST_MEM for the current `PC`; combinational, same-cycle.
- fetch_en  input  1  1 = fetch allowed; 0 = hold PC, no enqueue; the queue still drains.
- fetch_valid  output  1  queue head valid to decode.
- fetch_instr  output  32  queue head instruction.
- fetch_pc  output  32  PC of the queue head instruction.
- fetch_ready  input  1  decode accepts the head this cycle.
- redirect_valid  input  1  single-cycle request to restart fetch.
- redirect_pc  input  32  redirect target.
- addr_misaligned  output  1  one-cycle pulse: redirect target had nonzero `[1:0]`.

Behaviour:
- **Reset** (`reset`==0 at a clk edge):
  - `PC`<=RESET_PC; queue emptied; `fetch_valid`=0; `fetch_instr`=0; `fetch_pc`=0; `addr_misaligned`=0.
  - Reset asserted mid-operation discards all queued entries in that cycle. No partial state survives.
- **Definitions:**
  - pop = `fetch_valid` & `fetch_ready`.
  - push = `fetch_en` & !`redirect_valid` & (count<2 | pop).
- **Push:** enqueue {`PC`, `Instruction_Code`} at the tail, then `PC`<=`PC`+4.
  - Addition is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- **No push:** `PC` holds its value.
- **Pop:** head is removed; the next entry (if any) becomes head in the following cycle.
- **Simultaneous push and pop:**
  - Allowed when full (count stays 2).
  - Allowed when count==1 (count stays 1; the pushed entry becomes head).
- **Queue state:**
  - count in {0,1,2}.
  - `fetch_valid` = (count!=0).
  - Head outputs are registered from queue storage, never combinational from `Instruction_Code`.
- **Latency:** a PC presented in cycle N appears at the head with `fetch_valid`=1 in cycle N+1 if the queue was empty.
- **Redirect** (`redirect_valid`=1), highest priority after reset:
  - Queue flushed (count<=0); no push that cycle.
  - `PC`<={`redirect_pc[31:2]`,2'b00}.
  - A pop asserted in the same cycle still counts as a completed transfer (decode owns that instruction); the remaining entries are discarded.
  - First post-redirect instruction appears at the head 2 cycles after the redirect cycle (PC load, then fetch).
- **Misaligned redirect:**
  - If `redirect_pc[1:0]`!=0, `addr_misaligned`=1 for exactly the cycle after the redirect; otherwise 0.
  - The target is still taken, with the low bits cleared.
- **Output stability:** `fetch_valid`/`fetch_instr`/`fetch_pc` must hold steady while `fetch_valid`=1 & `fetch_ready`=0 (no redirect, no reset).
- **Ordering:** instructions leave in strictly increasing-PC order between redirects; no duplicates, no drops.
- **`fetch_en`=0:** no new fetches, but pops continue; queue can drain to empty.

Test Plan:
- **Reset and stream:** INST_MEM words at 0,4,8,12 = 32'h00500093, 32'h00A00113, 32'h002081B3, 32'h40208233; RESET_PC=0; deassert reset; `fetch_ready`=1 constantly -> `fetch_valid` rises 1 cycle after reset release; heads (pc,instr) = (0,00500093), (4,00A00113), (8,002081B3), (12,40208233) on consecutive cycles.
- **Backpressure:** `fetch_ready`=0 from reset release -> count reaches 2 with heads at PC 0 and 4; `PC` holds at 8; head stays (0,00500093). Raise `fetch_ready` -> order 0,4,8 continues with no gap or duplicate.
- **Redirect flush:** queue full (PCs 0,4), assert `redirect_valid` with `redirect_pc`=32'h40 and `fetch_ready`=1 in the same cycle -> PC-0 transfer counts; PC-4 entry is discarded; `PC`=32'h40 next cycle; head (32'h40, mem[16]) one cycle later; `addr_misaligned` stays 0.
- **Misaligned redirect:** `redirect_pc`=32'h0000_0046 -> `PC`=32'h44; `addr_misaligned`=1 for exactly one cycle.
- **Wrap and fetch_en:** RESET_PC=32'hFFFF_FFF8 -> heads at PCs FFFF_FFF8, FFFF_FFFC, 0000_0000. Drop `fetch_en` while 2 entries are queued -> queue drains; `PC` frozen; `fetch_valid` falls after 2 pops.
- **Reset mid-operation:** pull reset low with 2 entries queued and a redirect pending -> next cycle count=0, `fetch_valid`=0, `PC`=RESET_PC, `addr_misaligned`=0.
